// File: rtl/mem_stage_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage_lsu                                                |
// | Description : Memory-stage load/store unit with req/gnt/rvalid data bus,   |
// |               store lane alignment and load extraction.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

package mem_stage_lsu_pkg;

    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  ResultSrc;
        logic        MemWrite;
        logic [2:0]  funct3;
        logic [4:0]  Rd;
        logic [63:0] ALUResult;
        logic [63:0] WriteData;
        logic [63:0] PCPlus4;
        logic [63:0] ImmExt;
    } exmem_t;

    typedef struct packed {
        logic        RegWrite;
        logic [1:0]  ResultSrc;
        logic [4:0]  Rd;
        logic [63:0] ALUResult;
        logic [63:0] load_data;
        logic [63:0] PCPlus4;
        logic [63:0] ImmExt;
    } memwb_t;

endpackage

module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exmem_valid,
    input  exmem_t          exmem,
    output memwb_t          memwb,
    output logic            memwb_valid,
    output logic            stall_mem,
    output logic            misaligned,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [7:0]      dmem_be,
    output logic [63:0]     dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [63:0]     dmem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    // Copy of the in-flight instruction, valid outside IDLE
    logic        r_capMemWrite;
    logic [2:0]  r_capFunct3;
    logic        r_capRegWrite;
    logic [1:0]  r_capResultSrc;
    logic [4:0]  r_capRd;
    logic [63:0] r_capALUResult;
    logic [63:0] r_capPCPlus4;
    logic [63:0] r_capImmExt;
    logic [7:0]  r_capBe;
    logic [63:0] r_capWdata;

    logic        w_isStore;
    logic        w_isLoad;
    logic        w_isMem;
    logic        w_misal;
    logic [2:0]  w_offset;
    logic [7:0]  w_sizeMask;
    logic [7:0]  w_laneBe;
    logic [63:0] w_laneData;

    logic        w_req;
    logic        w_we;
    logic [63:0] w_addr;
    logic [7:0]  w_be;
    logic [63:0] w_wdata;
    logic        w_stall;
    logic        w_retire;
    logic        w_fromCap;
    logic        w_capture;
    logic        w_misalPulse;

    logic [63:0] w_ldShifted;
    logic [63:0] w_loadData;
    memwb_t      w_retireWb;

    assign w_isStore  = exmem.MemWrite;
    assign w_isLoad   = (exmem.ResultSrc == 2'b01) && !exmem.MemWrite;
    assign w_isMem    = w_isStore || w_isLoad;
    assign w_offset   = exmem.ALUResult[2:0];
    assign w_laneBe   = w_sizeMask << w_offset;
    assign w_laneData = exmem.WriteData << {w_offset, 3'b000};

    always_comb begin
        w_sizeMask = 8'h01;
        w_misal    = 1'b0;
        unique case (exmem.funct3[1:0])
            2'd0: begin w_sizeMask = 8'h01; w_misal = 1'b0;               end
            2'd1: begin w_sizeMask = 8'h03; w_misal = w_offset[0];        end
            2'd2: begin w_sizeMask = 8'h0F; w_misal = |w_offset[1:0];     end
            default: begin w_sizeMask = 8'hFF; w_misal = |w_offset;       end
        endcase
    end

    // Loads only retire from WAIT, so extraction always works on the captured copy
    assign w_ldShifted = dmem_rdata >> {r_capALUResult[2:0], 3'b000};

    always_comb begin
        w_loadData = w_ldShifted;
        unique case (r_capFunct3[1:0])
            2'd0: w_loadData = r_capFunct3[2] ? {56'd0, w_ldShifted[7:0]}
                                              : {{56{w_ldShifted[7]}}, w_ldShifted[7:0]};
            2'd1: w_loadData = r_capFunct3[2] ? {48'd0, w_ldShifted[15:0]}
                                              : {{48{w_ldShifted[15]}}, w_ldShifted[15:0]};
            2'd2: w_loadData = r_capFunct3[2] ? {32'd0, w_ldShifted[31:0]}
                                              : {{32{w_ldShifted[31]}}, w_ldShifted[31:0]};
            default: w_loadData = w_ldShifted;
        endcase
    end

    always_comb begin
        w_nextState  = r_state;
        w_req        = 1'b0;
        w_we         = 1'b0;
        w_addr       = '0;
        w_be         = '0;
        w_wdata      = '0;
        w_stall      = 1'b0;
        w_retire     = 1'b0;
        w_fromCap    = 1'b0;
        w_capture    = 1'b0;
        w_misalPulse = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (exmem_valid) begin
                    if (!w_isMem) begin
                        w_retire = 1'b1;
                    end else if (w_misal) begin
                        w_misalPulse = 1'b1;
                    end else begin
                        w_req     = 1'b1;
                        w_we      = w_isStore;
                        w_addr    = {exmem.ALUResult[63:3], 3'b000};
                        w_be      = w_laneBe;
                        w_wdata   = w_laneData;
                        w_capture = 1'b1;
                        if (dmem_gnt && w_isStore) begin
                            w_retire = 1'b1;
                        end else begin
                            w_stall     = 1'b1;
                            w_nextState = dmem_gnt ? S_WAIT : S_REQ;
                        end
                    end
                end
            end
            S_REQ: begin
                w_req     = 1'b1;
                w_we      = r_capMemWrite;
                w_addr    = {r_capALUResult[63:3], 3'b000};
                w_be      = r_capBe;
                w_wdata   = r_capWdata;
                w_fromCap = 1'b1;
                // Granted store leaves without a stall so upstream does not replay it
                if (dmem_gnt && r_capMemWrite) begin
                    w_retire    = 1'b1;
                    w_nextState = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (dmem_gnt) begin
                        w_nextState = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_fromCap = 1'b1;
                if (dmem_rvalid) begin
                    w_retire    = 1'b1;
                    w_nextState = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_retireWb = '0;
        if (w_fromCap) begin
            w_retireWb.RegWrite  = r_capRegWrite;
            w_retireWb.ResultSrc = r_capResultSrc;
            w_retireWb.Rd        = r_capRd;
            w_retireWb.ALUResult = r_capALUResult;
            w_retireWb.PCPlus4   = r_capPCPlus4;
            w_retireWb.ImmExt    = r_capImmExt;
        end else begin
            w_retireWb.RegWrite  = exmem.RegWrite;
            w_retireWb.ResultSrc = exmem.ResultSrc;
            w_retireWb.Rd        = exmem.Rd;
            w_retireWb.ALUResult = exmem.ALUResult;
            w_retireWb.PCPlus4   = exmem.PCPlus4;
            w_retireWb.ImmExt    = exmem.ImmExt;
        end
        w_retireWb.load_data = (r_state == S_WAIT) ? w_loadData : 64'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            memwb       <= '0;
            memwb_valid <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            misaligned  <= w_misalPulse;
            memwb_valid <= w_retire;
            memwb       <= w_retire ? w_retireWb : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_capMemWrite  <= 1'b0;
            r_capFunct3    <= '0;
            r_capRegWrite  <= 1'b0;
            r_capResultSrc <= '0;
            r_capRd        <= '0;
            r_capALUResult <= '0;
            r_capPCPlus4   <= '0;
            r_capImmExt    <= '0;
            r_capBe        <= '0;
            r_capWdata     <= '0;
        end else if (w_capture) begin
            r_capMemWrite  <= exmem.MemWrite;
            r_capFunct3    <= exmem.funct3;
            r_capRegWrite  <= exmem.RegWrite;
            r_capResultSrc <= exmem.ResultSrc;
            r_capRd        <= exmem.Rd;
            r_capALUResult <= exmem.ALUResult;
            r_capPCPlus4   <= exmem.PCPlus4;
            r_capImmExt    <= exmem.ImmExt;
            r_capBe        <= w_laneBe;
            r_capWdata     <= w_laneData;
        end
    end

    // Bus request and stall are forced low for the whole time reset is held
    assign dmem_req   = rst_n & w_req;
    assign stall_mem  = rst_n & w_stall;
    assign dmem_we    = w_we;
    assign dmem_addr  = w_addr;
    assign dmem_be    = w_be;
    assign dmem_wdata = w_wdata;

endmodule

`default_nettype wire
